// File: rtl/game_pkg.sv
// Shared types and widths for the game front-end blocks.
package game_pkg;
  localparam int ID_W      = 5;
  localparam int SCORE_W   = 7;
  localparam int MAX_SCORE = 99;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PLAY     = 3'd1,
    SUBMIT   = 3'd2,
    WAIT_ACK = 3'd3,
    DONE     = 3'd4
  } state_e;
endpackage

// File: rtl/game_score_feeder_if.sv
// Player-side controls and Scoring handshake for game_score_feeder.
interface game_score_feeder_if;
  import game_pkg::*;

  logic               login_valid;
  logic [ID_W-1:0]    login_id;
  logic               start;
  logic               abort;
  logic               hit;
  logic               miss;
  logic               tick;
  logic               score_ack;
  logic               score_request;
  logic [ID_W-1:0]    playerID;
  logic [SCORE_W-1:0] score;
  logic [7:0]         time_left;
  logic               game_active;
  logic               busy;
  logic               no_ack;

  modport master (
    output login_valid, login_id, start, abort, hit, miss, tick, score_ack,
    input  score_request, playerID, score, time_left, game_active, busy, no_ack
  );

  modport slave (
    input  login_valid, login_id, start, abort, hit, miss, tick, score_ack,
    output score_request, playerID, score, time_left, game_active, busy, no_ack
  );
endinterface

// File: rtl/sat_updown_counter.sv
// Up/down counter saturating at 0 and max_i; simultaneous inc and dec cancel.
module sat_updown_counter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic         clr_i,
  input  logic [W-1:0] max_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && !dec_i && (cnt_q < max_i))
      cnt_d = cnt_q + 1'b1;
    else if (dec_i && !inc_i && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/game_score_feeder.sv
// Runs one timed round per login and hands the final score to Scoring with an
// ack-or-timeout handshake.
module game_score_feeder
  import game_pkg::*;
#(
  parameter int GAME_TICKS  = 30,
  parameter int ACK_TIMEOUT = 64
) (
  input logic                clk,
  input logic                rst,
  game_score_feeder_if.slave bus
);
  localparam logic [7:0]         TICKS_INIT = 8'(GAME_TICKS);
  localparam logic [9:0]         ACK_INIT   = 10'(ACK_TIMEOUT - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = SCORE_W'(MAX_SCORE);

  state_e          state_q, state_d;
  logic            loaded_q;
  logic [ID_W-1:0] id_q;
  logic [7:0]      time_left_q;
  logic [9:0]      ack_cnt_q;
  logic            no_ack_q;
  logic            start_ok, final_tick, ack_tc, play_upd;
  logic [SCORE_W-1:0] score_cnt;

  // A simultaneous login wins over start so the new ID is never skipped.
  assign start_ok   = (state_q == IDLE) && bus.start && loaded_q && !bus.login_valid;
  assign final_tick = bus.tick && (time_left_q == 8'd1);
  assign ack_tc     = (ack_cnt_q == 10'd0);
  assign play_upd   = (state_q == PLAY) && !bus.abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start_ok) state_d = PLAY;
      PLAY:     if (bus.abort) state_d = IDLE;
                else if (final_tick) state_d = SUBMIT;
      SUBMIT:   state_d = WAIT_ACK;
      WAIT_ACK: if (bus.score_ack || ack_tc) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.score_request = 1'b0;
    bus.game_active   = 1'b0;
    bus.busy          = 1'b0;
    case (state_q)
      PLAY:     bus.game_active = 1'b1;
      SUBMIT:   begin bus.score_request = 1'b1; bus.busy = 1'b1; end
      WAIT_ACK: bus.busy = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loaded_q    <= 1'b0;
      id_q        <= '0;
      time_left_q <= '0;
      ack_cnt_q   <= '0;
      no_ack_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.login_valid) begin
            id_q     <= bus.login_id;
            loaded_q <= 1'b1;
          end
          if (start_ok) begin
            time_left_q <= TICKS_INIT;
            no_ack_q    <= 1'b0;
          end
        end
        PLAY: begin
          if (bus.abort) begin
            loaded_q    <= 1'b0;
            time_left_q <= '0;
          end else if (bus.tick) begin
            time_left_q <= time_left_q - 8'd1;
          end
        end
        SUBMIT: ack_cnt_q <= ACK_INIT;
        WAIT_ACK: begin
          // Ack on the terminal cycle takes precedence over the timeout flag.
          if (!bus.score_ack) begin
            if (ack_tc) no_ack_q  <= 1'b1;
            else        ack_cnt_q <= ack_cnt_q - 10'd1;
          end
        end
        DONE:    loaded_q <= 1'b0;
        default: ;
      endcase
    end
  end

  sat_updown_counter #(.W(SCORE_W)) u_score (
    .clk   (clk),
    .rst   (rst),
    .inc_i (play_upd && bus.hit),
    .dec_i (play_upd && bus.miss),
    .clr_i (start_ok),
    .max_i (SCORE_MAX),
    .cnt_o (score_cnt)
  );

  assign bus.playerID  = id_q;
  assign bus.score     = score_cnt;
  assign bus.time_left = time_left_q;
  assign bus.no_ack    = no_ack_q;
endmodule

// File: tb/tb_game_score_feeder.sv
// Directed bench for game_score_feeder: rounds, saturation, abort, ack/timeout.
module tb_game_score_feeder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   req_cnt = 0;

  game_score_feeder_if bus();

  game_score_feeder #(.GAME_TICKS(30), .ACK_TIMEOUT(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst && bus.score_request) req_cnt++;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic login(input logic [4:0] id);
    bus.login_id = id; bus.login_valid = 1'b1; cyc(1); bus.login_valid = 1'b0;
  endtask

  task automatic start_rnd();
    bus.start = 1'b1; cyc(1); bus.start = 1'b0;
  endtask

  task automatic hits(input int n);
    bus.hit = 1'b1; cyc(n); bus.hit = 1'b0;
  endtask

  task automatic misses(input int n);
    bus.miss = 1'b1; cyc(n); bus.miss = 1'b0;
  endtask

  task automatic ticks(input int n);
    bus.tick = 1'b1; cyc(n); bus.tick = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    bus.login_valid = 0; bus.login_id = '0; bus.start = 0; bus.abort = 0;
    bus.hit = 0; bus.miss = 0; bus.tick = 0; bus.score_ack = 0;
    cyc(2);
    chk("rst_active", bus.game_active, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_score", bus.score, 0);
    chk("rst_tleft", bus.time_left, 0);
    chk("rst_id", bus.playerID, 0);
    chk("rst_noack", bus.no_ack, 0);
    rst = 1'b1;
    cyc(1);

    // 1: reset in the middle of a round
    login(5'd7);
    start_rnd();
    chk("t1_active", bus.game_active, 1);
    chk("t1_tleft", bus.time_left, 30);
    hits(5);
    ticks(3);
    chk("t1_score", bus.score, 5);
    chk("t1_tleft27", bus.time_left, 27);
    #2 rst = 1'b0;
    #1;
    chk("t1_rst_active", bus.game_active, 0);
    chk("t1_rst_score", bus.score, 0);
    chk("t1_rst_tleft", bus.time_left, 0);
    chk("t1_rst_id", bus.playerID, 0);
    @(posedge clk); #1 rst = 1'b1;
    cyc(1);
    chk("t1_noreq", req_cnt, 0);

    // 2: normal round with ack
    login(5'd1);
    start_rnd();
    hits(15);
    ticks(29);
    chk("t2_tleft1", bus.time_left, 1);
    chk("t2_still_play", bus.game_active, 1);
    ticks(1);
    chk("t2_req", bus.score_request, 1);
    chk("t2_id", bus.playerID, 1);
    chk("t2_score", bus.score, 15);
    chk("t2_tleft0", bus.time_left, 0);
    chk("t2_busy", bus.busy, 1);
    cyc(1);
    chk("t2_req_once", bus.score_request, 0);
    chk("t2_wait_busy", bus.busy, 1);
    bus.score_ack = 1'b1; cyc(1); bus.score_ack = 1'b0;
    chk("t2_done_busy", bus.busy, 0);
    cyc(1);
    chk("t2_reqcnt", req_cnt, 1);
    chk("t2_noack", bus.no_ack, 0);
    chk("t2_score_hold", bus.score, 15);
    start_rnd();
    chk("t2_relogin_needed", bus.game_active, 0);

    // 3: saturation and paired pulses
    login(5'd4);
    start_rnd();
    hits(105);
    chk("t3_sat", bus.score, 99);
    bus.hit = 1'b1; bus.miss = 1'b1; cyc(2); bus.hit = 1'b0; bus.miss = 1'b0;
    chk("t3_pair", bus.score, 99);
    misses(3);
    chk("t3_final", bus.score, 96);
    bus.abort = 1'b1; cyc(1); bus.abort = 1'b0;
    chk("t3_abort_active", bus.game_active, 0);
    chk("t3_abort_tleft", bus.time_left, 0);

    // 4: start gating and floor saturation
    start_rnd();
    chk("t4_nologin", bus.game_active, 0);
    bus.login_id = 5'd9; bus.login_valid = 1'b1; bus.start = 1'b1;
    cyc(1);
    bus.login_valid = 1'b0; bus.start = 1'b0;
    chk("t4_both_idle", bus.game_active, 0);
    chk("t4_both_id", bus.playerID, 9);
    start_rnd();
    chk("t4_play", bus.game_active, 1);
    misses(2);
    chk("t4_floor", bus.score, 0);
    bus.abort = 1'b1; cyc(1); bus.abort = 1'b0;

    // 5: timeout with stable outputs, gameplay inputs ignored while waiting
    login(5'd2);
    start_rnd();
    hits(70);
    ticks(30);
    chk("t5_req", bus.score_request, 1);
    bad = 0;
    bus.hit = 1'b1; bus.tick = 1'b1;
    for (int i = 0; i < 64; i++) begin
      cyc(1);
      if (bus.playerID != 2 || bus.score != 70 || bus.busy != 1 || bus.no_ack != 0) bad++;
    end
    bus.hit = 1'b0; bus.tick = 1'b0;
    chk("t5_hold", bad, 0);
    cyc(1);
    chk("t5_done_busy", bus.busy, 0);
    chk("t5_noack", bus.no_ack, 1);
    cyc(1);
    chk("t5_noack_sticky", bus.no_ack, 1);
    chk("t5_reqcnt", req_cnt, 2);

    // 6: abort on final tick, then ack on the timeout cycle
    login(5'd5);
    start_rnd();
    chk("t6_noack_clr", bus.no_ack, 0);
    ticks(29);
    bus.tick = 1'b1; bus.abort = 1'b1; cyc(1); bus.tick = 1'b0; bus.abort = 1'b0;
    chk("t6_abort_active", bus.game_active, 0);
    chk("t6_abort_busy", bus.busy, 0);
    cyc(2);
    chk("t6_abort_noreq", req_cnt, 2);
    login(5'd3);
    start_rnd();
    hits(80);
    ticks(30);
    chk("t6_req", bus.score_request, 1);
    cyc(64);
    chk("t6_last_wait", bus.busy, 1);
    bus.score_ack = 1'b1; cyc(1); bus.score_ack = 1'b0;
    chk("t6_done_busy", bus.busy, 0);
    chk("t6_noack", bus.no_ack, 0);
    cyc(1);
    chk("t6_id", bus.playerID, 3);
    chk("t6_score", bus.score, 80);
    chk("t6_reqcnt", req_cnt, 3);
    bus.score_ack = 1'b1; cyc(2); bus.score_ack = 1'b0;
    chk("t6_stray_ack", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
